register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
- Parametrised N-bit register file with 2**ADDR_W entries, one write port and two independent registered read ports.
- Adds a sequenced bulk-clear engine with a Busy flag.
- Serves as the general-purpose operand store for datapath blocks that need two operands and one result per clock.

Parameters:
N, 4, data width in bits of every register and data port
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers (derived, not overridable)

Ports:
Clk  input  1  clock; all state updates on falling edge
Reset  input  1  synchronous, active-high reset, sampled on falling edge of Clk
Enable  input  1  global enable; when low all state holds
WrEn  input  1  write request
WrAddr  input  ADDR_W  write address
WrData  input  N  write data
RdEnA  input  1  read request, port A
RdAddrA  input  ADDR_W  read address, port A
RdDataA  output  N  registered read data, port A
RdValidA  output  1  RdDataA updated by a read on the last edge
RdEnB  input  1  read request, port B
RdAddrB  input  ADDR_W  read address, port B
RdDataB  output  N  registered read data, port B
RdValidB  output  1  RdDataB updated by a read on the last edge
Clear  input  1  request sequential zeroing of all registers
Busy  output  1  clear sequence in progress

Behaviour:
- Interface: one clock; reset is synchronous and active-high (Clk, Reset); all state changes on the falling edge of Clk.
- Reset (priority over everything):
  - all DEPTH registers = 0; RdDataA/B = 0; RdValidA/B = 0; Busy = 0.
  - state = IDLE; clear pointer = 0.
  - Applies mid-clear: sequence aborts.
- Enable low:
  - registers, state, pointer and RdDataA/B hold; RdValidA/B forced to 0.
  - An active clear pauses and resumes when Enable returns high.
- State machine: IDLE, CLEAR.
  - Busy = (state == CLEAR), a registered flag.
- IDLE, Enable high:
  - Write: if WrEn, reg[WrAddr] <= WrData.
  - Read X (A or B): if RdEnX, RdDataX <= reg[RdAddrX] and RdValidX <= 1. Otherwise RdValidX <= 0 and RdDataX holds.
  - Read latency 1 edge; data is never tri-stated.
  - Read-during-write, same edge, same address: write-first bypass, RdDataX <= WrData. Applies independently to each port; both ports may bypass together.
  - A and B may read the same address simultaneously; both return the same value.
  - Clear high: state -> CLEAR, pointer <= 0. Writes and reads on this same edge still execute normally.
- CLEAR, Enable high:
  - Each edge: reg[pointer] <= 0, pointer <= pointer + 1.
  - Edge with pointer == DEPTH-1: zero that entry, pointer <= 0, state -> IDLE.
  - Busy is high for exactly DEPTH enabled edges.
  - WrEn, RdEnA/B and Clear are ignored; RdValidA/B = 0; RdDataA/B hold.
- Pointer width is ADDR_W and wraps naturally; no out-of-range addresses exist.
- Outputs change only on falling edges; there are no combinational input-to-output paths.

Test Plan (N=4, ADDR_W=3):
- Reset high 2 edges, then read A at addresses 0..7 on consecutive edges -> RdDataA = 0x0 each edge after the request, RdValidA = 1 one edge after each request; RdValidB = 0 throughout.
- Write reg[i] = i+8 for i = 0..7, then same edge RdAddrA = 3, RdAddrB = 5 -> next edge RdDataA = 0xB, RdDataB = 0xD, both valid.
- With reg[2] = 0xA, same edge WrAddr = 2, WrData = 0x7, RdAddrA = 2, RdAddrB = 2 -> RdDataA = RdDataB = 0x7; a later read of 2 returns 0x7.
- Pulse Clear 1 edge -> Busy = 1 for exactly 8 edges. Write 0xF to address 1 during Busy -> ignored. Read request during Busy -> RdValid = 0. After Busy falls, all 8 reads = 0x0.
- Start clear, drop Enable for 3 edges after the 2nd clear edge -> Busy high for 11 edges total. Repeat with Reset asserted on the 4th clear edge -> Busy = 0 and all registers = 0 on the next edge.
- Enable = 0 with WrEn = 1 (WrAddr = 6, WrData = 0x5) and RdEnA = 1 -> reg[6] unchanged, RdValidA = 0, RdDataA held.

Source files
------------

// File: rtl/register_file_2r1w.sv
// Two-read/one-write register file with write-first bypass and a sequenced
// bulk-clear engine. All state updates on the falling edge of Clk.
module register_file_2r1w #(
  parameter int N      = 4,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [N-1:0]      WrData,
  input  logic              RdEnA,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [N-1:0]      RdDataA,
  output logic              RdValidA,
  input  logic              RdEnB,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [N-1:0]      RdDataB,
  output logic              RdValidB,
  input  logic              Clear,
  output logic              Busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_W-1:0]       ptr_reg, ptr_next;
  logic                    wr_go, clr_go, rd_go_a, rd_go_b;
  logic [DEPTH-1:0][N-1:0] mem_q;

  logic [N-1:0] rd_data_a_reg, rd_data_b_reg;
  logic         rd_valid_a_reg, rd_valid_b_reg;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    wr_go      = 1'b0;
    clr_go     = 1'b0;
    rd_go_a    = 1'b0;
    rd_go_b    = 1'b0;
    if (Enable) begin
      case (state_reg)
        IDLE: begin
          wr_go   = WrEn;
          rd_go_a = RdEnA;
          rd_go_b = RdEnB;
          if (Clear) begin
            state_next = CLEAR;
            ptr_next   = '0;
          end
        end
        CLEAR: begin
          clr_go   = 1'b1;
          // Pointer wraps to 0 naturally on the last entry.
          ptr_next = ptr_reg + ADDR_W'(1);
          if (ptr_reg == ADDR_W'(DEPTH - 1))
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(negedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // One storage element per entry; clearing has priority over writing.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [N-1:0] q_reg;
    always_ff @(negedge Clk) begin
      if (Reset)
        q_reg <= '0;
      else if (clr_go && ptr_reg == ADDR_W'(gi))
        q_reg <= '0;
      else if (wr_go && WrAddr == ADDR_W'(gi))
        q_reg <= WrData;
    end
    assign mem_q[gi] = q_reg;
  end

  always_ff @(negedge Clk) begin
    if (Reset) begin
      rd_data_a_reg  <= '0;
      rd_valid_a_reg <= 1'b0;
    end else begin
      rd_valid_a_reg <= rd_go_a;
      if (rd_go_a)
        rd_data_a_reg <= (wr_go && WrAddr == RdAddrA) ? WrData : mem_q[RdAddrA];
    end
  end

  always_ff @(negedge Clk) begin
    if (Reset) begin
      rd_data_b_reg  <= '0;
      rd_valid_b_reg <= 1'b0;
    end else begin
      rd_valid_b_reg <= rd_go_b;
      if (rd_go_b)
        rd_data_b_reg <= (wr_go && WrAddr == RdAddrB) ? WrData : mem_q[RdAddrB];
    end
  end

  assign RdDataA  = rd_data_a_reg;
  assign RdValidA = rd_valid_a_reg;
  assign RdDataB  = rd_data_b_reg;
  assign RdValidB = rd_valid_b_reg;
  assign Busy     = (state_reg == CLEAR);

endmodule

// File: tb/tb_register_file_2r1w.sv
// Scoreboard bench for register_file_2r1w: a behavioural model pushes the
// expected outputs per edge, which are popped and compared after the edge.
module tb_register_file_2r1w;

  logic       Clk, Reset, Enable, WrEn, RdEnA, RdEnB, Clear;
  logic [2:0] WrAddr, RdAddrA, RdAddrB;
  logic [3:0] WrData, RdDataA, RdDataB;
  logic       RdValidA, RdValidB, Busy;

  register_file_2r1w #(.N(4), .ADDR_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(RdDataA), .RdValidA(RdValidA),
    .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(RdDataB), .RdValidB(RdValidB),
    .Clear(Clear), .Busy(Busy)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] da;
    logic       va;
    logic [3:0] db;
    logic       vb;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_tick = 0;

  logic [3:0] m_mem [8];
  logic       m_busy = 1'b0;
  logic [2:0] m_ptr = 3'd0;
  logic [3:0] m_da = 4'h0, m_db = 4'h0;
  logic       m_va = 1'b0, m_vb = 1'b0;

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one falling edge using the currently driven inputs.
  task automatic model_edge();
    exp_t e;
    if (Reset) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
      m_busy = 1'b0; m_ptr = 3'd0;
      m_da = 4'h0; m_db = 4'h0; m_va = 1'b0; m_vb = 1'b0;
    end else if (!Enable) begin
      m_va = 1'b0; m_vb = 1'b0;
    end else if (m_busy) begin
      m_mem[m_ptr] = 4'h0;
      m_va = 1'b0; m_vb = 1'b0;
      if (m_ptr == 3'd7) m_busy = 1'b0;
      m_ptr = m_ptr + 3'd1;
    end else begin
      m_va = RdEnA;
      m_vb = RdEnB;
      if (RdEnA) m_da = (WrEn && WrAddr == RdAddrA) ? WrData : m_mem[RdAddrA];
      if (RdEnB) m_db = (WrEn && WrAddr == RdAddrB) ? WrData : m_mem[RdAddrB];
      if (WrEn) m_mem[WrAddr] = WrData;
      if (Clear) begin
        m_busy = 1'b1;
        m_ptr  = 3'd0;
      end
    end
    e.da = m_da; e.va = m_va; e.db = m_db; e.vb = m_vb; e.busy = m_busy;
    sb_q.push_back(e);
  endtask

  // One transaction: push expectation, let the falling edge happen, pop and compare.
  task automatic tick();
    exp_t e;
    model_edge();
    @(negedge Clk);
    #1;
    n_tick++;
    e = sb_q.pop_front();
    $display("tick %0d rst=%b en=%b wr=%b@%0d=%h clr=%b | A v=%b d=%h  B v=%b d=%h busy=%b",
             n_tick, Reset, Enable, WrEn, WrAddr, WrData, Clear,
             RdValidA, RdDataA, RdValidB, RdDataB, Busy);
    chk_val("RdDataA",  {4'h0, RdDataA},  {4'h0, e.da});
    chk_val("RdValidA", {7'h0, RdValidA}, {7'h0, e.va});
    chk_val("RdDataB",  {4'h0, RdDataB},  {4'h0, e.db});
    chk_val("RdValidB", {7'h0, RdValidB}, {7'h0, e.vb});
    chk_val("Busy",     {7'h0, Busy},     {7'h0, e.busy});
  endtask

  task automatic idle_inputs();
    WrEn = 1'b0; WrAddr = 3'd0; WrData = 4'h0;
    RdEnA = 1'b0; RdAddrA = 3'd0; RdEnB = 1'b0; RdAddrB = 3'd0;
    Clear = 1'b0;
  endtask

  task automatic fill(input logic [3:0] base);
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      WrEn = 1'b1; WrAddr = 3'(i); WrData = 4'(i) + base;
      tick();
    end
    idle_inputs();
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      RdEnA = 1'b1; RdAddrA = 3'(i);
      RdEnB = 1'b1; RdAddrB = 3'(7 - i);
      tick();
      chk_val(tag, {RdDataA, RdDataB}, 8'h00);
    end
    idle_inputs();
  endtask

  int busy_cnt;

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
    idle_inputs();
    Reset = 1'b1; Enable = 1'b1;
    tick();
    tick();
    chk_val("reset_busy", {7'h0, Busy}, 8'h00);
    Reset = 1'b0;

    // Reads after reset return zero.
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      RdEnA = 1'b1; RdAddrA = 3'(i);
      tick();
      chk_val("rst_read", {3'h0, RdValidA, RdDataA}, 8'h10);
    end

    // Fill reg[i] = i+8, then dual read.
    fill(4'h8);
    RdEnA = 1'b1; RdAddrA = 3'd3; RdEnB = 1'b1; RdAddrB = 3'd5;
    tick();
    chk_val("dual_read", {RdDataA, RdDataB}, 8'hBD);

    // Write-first bypass on both ports.
    idle_inputs();
    WrEn = 1'b1; WrAddr = 3'd2; WrData = 4'h7;
    RdEnA = 1'b1; RdAddrA = 3'd2; RdEnB = 1'b1; RdAddrB = 3'd2;
    tick();
    chk_val("bypass", {RdDataA, RdDataB}, 8'h77);
    idle_inputs();
    RdEnA = 1'b1; RdAddrA = 3'd2;
    tick();
    chk_val("after_bypass", {4'h0, RdDataA}, 8'h07);

    // Clear: busy for exactly 8 edges, requests ignored meanwhile.
    idle_inputs();
    Clear = 1'b1;
    tick();
    busy_cnt = int'(Busy);
    idle_inputs();
    WrEn = 1'b1; WrAddr = 3'd1; WrData = 4'hF; RdEnA = 1'b1; RdAddrA = 3'd1;
    repeat (8) begin
      tick();
      busy_cnt += int'(Busy);
    end
    chk_val("busy_len", 8'(busy_cnt), 8'd8);
    read_all_zero("clear_zero");

    // Clear paused by 3 disabled edges after the 2nd clear edge.
    fill(4'h1);
    Clear = 1'b1;
    tick();
    busy_cnt = int'(Busy);
    idle_inputs();
    for (int k = 1; k <= 14; k++) begin
      Enable = !(k >= 3 && k <= 5);
      tick();
      busy_cnt += int'(Busy);
    end
    Enable = 1'b1;
    chk_val("busy_paused", 8'(busy_cnt), 8'd11);
    read_all_zero("pause_zero");

    // Reset on the 4th clear edge aborts the sequence.
    fill(4'h3);
    Clear = 1'b1;
    tick();
    idle_inputs();
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    chk_val("abort_busy", {7'h0, Busy}, 8'h00);
    Reset = 1'b0;
    read_all_zero("abort_zero");

    // Enable low: no write, no valid, data held.
    idle_inputs();
    WrEn = 1'b1; WrAddr = 3'd6; WrData = 4'h9;
    tick();
    idle_inputs();
    WrEn = 1'b1; WrAddr = 3'd3; WrData = 4'hC;
    tick();
    idle_inputs();
    RdEnA = 1'b1; RdAddrA = 3'd3;
    tick();
    chk_val("pre_hold", {4'h0, RdDataA}, 8'h0C);
    Enable = 1'b0;
    WrEn = 1'b1; WrAddr = 3'd6; WrData = 4'h5; RdEnA = 1'b1; RdAddrA = 3'd6;
    tick();
    chk_val("disabled", {3'h0, RdValidA, RdDataA}, 8'h0C);
    Enable = 1'b1;
    idle_inputs();
    RdEnA = 1'b1; RdAddrA = 3'd6;
    tick();
    chk_val("reg6_kept", {3'h0, RdValidA, RdDataA}, 8'h19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
